// File: rtl/icache_fill_unit.sv
// I-cache miss handler: captures one miss, issues a block-aligned DRAM read,
// assembles the beats into a block and writes it back as a single-cycle fill.
module icache_fill_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 64,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  flush,
  output logic                  busy,
  output logic                  dram_req_valid,
  input  logic                  dram_req_ready,
  output logic [ADDR_WIDTH-1:0] dram_req_addr,
  input  logic                  dram_resp_valid,
  input  logic [BEAT_WIDTH-1:0] dram_resp_data,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [BLOCK_SIZE-1:0] fill_data
);

  localparam int N_BEATS  = BLOCK_SIZE / BEAT_WIDTH;
  localparam int CNT_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OFF_BITS = $clog2(BLOCK_SIZE / 8);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFF_BITS) - 64'd1);
  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(N_BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_FILL = 2'd3;

  logic [1:0]            state;
  logic                  squash;
  logic [CNT_W-1:0]      beat_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BLOCK_SIZE-1:0] blk_q;
  logic [BLOCK_SIZE-1:0] blk_d;

  // Incoming beat lands in the slot selected by the beat counter.
  always_comb begin
    blk_d = blk_q;
    for (int unsigned i = 0; i < N_BEATS; i++) begin
      if (beat_cnt == CNT_W'(i)) begin
        blk_d[i*BEAT_WIDTH +: BEAT_WIDTH] = dram_resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      squash   <= 1'b0;
      beat_cnt <= '0;
      addr_q   <= '0;
      blk_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_valid && !flush) begin
            addr_q <= miss_addr & ALIGN_MASK;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          // An accepted request must still drain its beats even if flushed.
          if (dram_req_ready) begin
            state    <= S_WAIT;
            beat_cnt <= '0;
            squash   <= flush;
          end else if (flush) begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (dram_resp_valid) begin
            blk_q <= blk_d;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt <= '0;
              squash   <= 1'b0;
              state    <= (squash || flush) ? S_IDLE : S_FILL;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
              squash   <= squash | flush;
            end
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
        S_FILL: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy           = (state != S_IDLE);
  assign dram_req_valid = (state == S_REQ);
  assign dram_req_addr  = addr_q;
  assign fill_valid     = (state == S_FILL);
  assign fill_addr      = addr_q;
  assign fill_data      = blk_q;

endmodule

// File: tb/tb_icache_fill_unit.sv
// Bench for icache_fill_unit: directed scenarios with literal expectations,
// then randomized traffic checked each cycle against a transaction-level model.
module tb_icache_fill_unit;

  localparam int AW = 32;
  localparam int BS = 64;
  localparam int BW = 32;
  localparam int NB = BS / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_valid;
  logic [AW-1:0] miss_addr;
  logic          flush;
  logic          busy;
  logic          dram_req_valid;
  logic          dram_req_ready;
  logic [AW-1:0] dram_req_addr;
  logic          dram_resp_valid;
  logic [BW-1:0] dram_resp_data;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [BS-1:0] fill_data;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  bit started = 1'b0;

  icache_fill_unit #(.ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .BEAT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .flush(flush), .busy(busy), .dram_req_valid(dram_req_valid),
    .dram_req_ready(dram_req_ready), .dram_req_addr(dram_req_addr),
    .dram_resp_valid(dram_resp_valid), .dram_resp_data(dram_resp_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending request, an outstanding transfer collecting beats, a fill slot.
  bit            m_req, m_wait, m_fill, m_squash;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_beats[$];
  logic [BS-1:0] m_block;

  always @(posedge clk) begin
    if (rst) begin
      m_req = 0; m_wait = 0; m_fill = 0; m_squash = 0; m_beats.delete();
      started = 1'b1;
    end else if (m_fill) begin
      m_fill = 0;
    end else if (m_req) begin
      if (dram_req_ready) begin
        hs_cnt++;
        m_req = 0; m_wait = 1; m_squash = flush; m_beats.delete();
      end else if (flush) begin
        m_req = 0;
      end
    end else if (m_wait) begin
      if (flush) m_squash = 1;
      if (dram_resp_valid) begin
        m_beats.push_back(dram_resp_data);
        if (m_beats.size() == NB) begin
          m_block = '0;
          for (int i = 0; i < NB; i++) m_block = m_block | (BS'(m_beats[i]) << (BW * i));
          m_wait = 0;
          m_fill = !m_squash;
          m_squash = 0;
        end
      end
    end else if (miss_valid && !flush) begin
      m_req  = 1;
      m_addr = (miss_addr / (BS / 8)) * (BS / 8);
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("busy", 64'(busy), 64'(m_req || m_wait || m_fill));
      chk("req_valid", 64'(dram_req_valid), 64'(m_req));
      if (m_req) chk("req_addr", 64'(dram_req_addr), 64'(m_addr));
      chk("fill_valid", 64'(fill_valid), 64'(m_fill));
      if (m_fill) begin
        chk("fill_addr", 64'(fill_addr), 64'(m_addr));
        chk("fill_data", fill_data, m_block);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    miss_valid = 0; flush = 0; dram_resp_valid = 0; dram_req_ready = 1; rst = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      cyc();
      idle_in();
      dram_resp_valid = 1;
      dram_resp_data  = $urandom;
      @(negedge clk);
      if (!busy) break;
    end
    chk("drain_idle", 64'(busy), 64'd0);
    cyc();
    idle_in();
  endtask

  initial begin
    int hs0;
    rst = 1; miss_valid = 1; miss_addr = 32'h1004; flush = 0;
    dram_req_ready = 1; dram_resp_valid = 0; dram_resp_data = '0;
    cyc();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req", 64'(dram_req_valid), 64'd0);
      chk("rst_fill", 64'(fill_valid), 64'd0);
      chk("rst_req_addr", 64'(dram_req_addr), 64'd0);
      chk("rst_fill_data", fill_data, 64'd0);
      cyc();
    end
    idle_in();
    @(negedge clk);
    chk("post_rst_idle", 64'(busy), 64'd0);

    // Basic fill
    cyc(); idle_in(); miss_valid = 1; miss_addr = 32'h0000_1004;
    cyc(); idle_in();
    @(negedge clk);
    chk("basic_req_valid", 64'(dram_req_valid), 64'd1);
    chk("basic_req_addr", 64'(dram_req_addr), 64'h1000);
    cyc(); idle_in();
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'hAAAA_0001;
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'hBBBB_0002;
    cyc(); idle_in();
    @(negedge clk);
    chk("basic_fill_valid", 64'(fill_valid), 64'd1);
    chk("basic_fill_addr", 64'(fill_addr), 64'h1000);
    chk("basic_fill_data", fill_data, 64'hBBBB_0002_AAAA_0001);
    cyc(); idle_in();
    @(negedge clk);
    chk("basic_done", 64'(busy), 64'd0);

    // Backpressure
    hs0 = hs_cnt;
    cyc(); idle_in(); dram_req_ready = 0; miss_valid = 1; miss_addr = 32'h0000_1004;
    for (int t = 1; t <= 5; t++) begin
      cyc(); idle_in(); dram_req_ready = (t == 5);
      @(negedge clk);
      chk("bp_req_valid", 64'(dram_req_valid), 64'd1);
      chk("bp_req_addr", 64'(dram_req_addr), 64'h1000);
    end
    drain();
    chk("bp_one_handshake", 64'(hs_cnt - hs0), 64'd1);

    // Flush before handshake, then a stray beat
    cyc(); idle_in(); dram_req_ready = 0; miss_valid = 1; miss_addr = 32'h3008;
    cyc(); idle_in(); dram_req_ready = 0;
    cyc(); idle_in(); dram_req_ready = 0; flush = 1;
    cyc(); idle_in();
    @(negedge clk);
    chk("fl_req_dropped", 64'(dram_req_valid), 64'd0);
    chk("fl_idle", 64'(busy), 64'd0);
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'hDEAD_BEEF;
    cyc(); idle_in();
    @(negedge clk);
    chk("fl_stray_ignored", 64'(busy), 64'd0);

    // Flush during WAIT, then a new miss right after
    cyc(); idle_in(); miss_valid = 1; miss_addr = 32'h4000;
    cyc(); idle_in();
    cyc(); idle_in(); flush = 1;
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'h1111_1111;
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'h2222_2222;
    cyc(); idle_in(); miss_valid = 1; miss_addr = 32'h2000;
    @(negedge clk);
    chk("fw_no_fill", 64'(fill_valid), 64'd0);
    cyc(); idle_in();
    @(negedge clk);
    chk("fw_new_req", 64'(dram_req_valid), 64'd1);
    chk("fw_new_addr", 64'(dram_req_addr), 64'h2000);
    drain();

    // Miss while busy, then miss+flush collision in IDLE
    hs0 = hs_cnt;
    cyc(); idle_in(); miss_valid = 1; miss_addr = 32'h5000;
    cyc(); idle_in();
    cyc(); idle_in(); miss_valid = 1; miss_addr = 32'h6000;
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'h5555_0000;
    cyc(); idle_in(); dram_resp_valid = 1; dram_resp_data = 32'h5555_0001;
    cyc(); idle_in();
    @(negedge clk);
    chk("mb_fill_addr", 64'(fill_addr), 64'h5000);
    cyc(); idle_in();
    chk("mb_one_handshake", 64'(hs_cnt - hs0), 64'd1);
    cyc(); idle_in(); miss_valid = 1; flush = 1; miss_addr = 32'h7000;
    cyc(); idle_in();
    @(negedge clk);
    chk("coll_no_req", 64'(dram_req_valid), 64'd0);
    chk("coll_idle", 64'(busy), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rst             = ($urandom_range(0, 199) == 0);
      miss_valid      = ($urandom_range(0, 9) < 3);
      miss_addr       = $urandom;
      flush           = ($urandom_range(0, 19) == 0);
      dram_req_ready  = ($urandom_range(0, 1) == 1);
      dram_resp_valid = ($urandom_range(0, 9) < 4);
      dram_resp_data  = $urandom;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_fill_unit.md
Name: icache_fill_unit

Overview:
Miss handler directly upstream of the instruction fetch unit's I-cache.
- Captures an I-cache miss and issues one block-aligned request to DRAM.
- Assembles the multi-beat DRAM response into a full cache block and presents it to the I-cache write port as a single-cycle fill.
- Tracks one outstanding miss at a time.
- Squashes in-flight misses on a front-end redirect (recovery) so wrong-path blocks are never written.

Parameters:
ADDR_WIDTH, 32, fetch address width
BLOCK_SIZE, 64, I-cache block size in bits (must be a multiple of BEAT_WIDTH and a power of two ≥ 8)
BEAT_WIDTH, 32, DRAM response data width per beat
N_BEATS, BLOCK_SIZE/BEAT_WIDTH, beats per block (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
miss_valid  in  1  I-cache missed on miss_addr this cycle
miss_addr  in  ADDR_WIDTH  fetch PC that missed
flush  in  1  recovery redirect; squash current miss
busy  out  1  high whenever state != IDLE
dram_req_valid  out  1  DRAM read request valid
dram_req_ready  in  1  DRAM accepts request
dram_req_addr  out  ADDR_WIDTH  block-aligned request address
dram_resp_valid  in  1  one response beat valid
dram_resp_data  in  BEAT_WIDTH  response beat
fill_valid  out  1  write fill_data into I-cache this cycle
fill_addr  out  ADDR_WIDTH  block-aligned address of fill
fill_data  out  BLOCK_SIZE  assembled block

Behaviour:

Reset:
- rst high at a clock edge forces state IDLE and clears the squash flag and the beat counter.
- Outputs go to 0: busy, dram_req_valid, fill_valid, dram_req_addr, fill_addr and fill_data.
- Reset mid-operation abandons everything. Any later DRAM beats for the abandoned request arrive while IDLE and are ignored.

Address alignment:
- The captured address is miss_addr with its low log2(BLOCK_SIZE/8) bits forced to 0.
- Defaults: 3 bits cleared, so 0x1004 becomes 0x1000.

States:
- IDLE: miss_valid=1 and flush=0 captures the aligned address and moves to REQ next cycle. If miss_valid and flush are both high, flush wins and nothing is captured. dram_resp_valid is ignored.
- REQ:
  - dram_req_valid=1, with dram_req_addr held stable until the handshake.
  - The handshake (valid&&ready) moves to WAIT and clears the beat counter.
  - flush before or in the handshake cycle: if ready=0 that cycle, go to IDLE with no request issued. If ready=1 the same cycle, go to WAIT with squash=1.
- WAIT:
  - On each dram_resp_valid, write the beat into bits [k*BEAT_WIDTH +: BEAT_WIDTH] of the assembly buffer, where k is the beat counter (beat 0 is the least significant), then increment k.
  - On the last beat (k=N_BEATS-1): go to FILL if squash=0; otherwise go to IDLE with no fill and clear squash.
  - flush in WAIT sets squash; the remaining beats are still consumed.
- FILL: fill_valid=1 for exactly one cycle, with fill_addr = captured address and fill_data = buffer. Then go to IDLE. A flush during FILL does not cancel the fill, because block contents are path-independent.

Other rules:
- miss_valid outside IDLE is ignored; no queueing. The fetch unit re-presents the miss after fill.
- The beat counter is log2(N_BEATS) bits wide, minimum 1, and never wraps mid-block.

Latency:
- miss at cycle t gives dram_req_valid at t+1 (with ready=1, handshake at t+1).
- The last beat at cycle u gives fill_valid at u+1.
- A new miss is accepted in the cycle after FILL.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with miss_valid=1 -> busy=0, dram_req_valid=0, fill_valid=0 throughout. The first cycle after release is still IDLE.
2. Basic fill:
   - Stimulus: miss_addr=0x0000_1004 at t0, dram_req_ready=1; beats 0xAAAA_0001 at t3 and 0xBBBB_0002 at t4.
   - Response: dram_req_addr=0x0000_1000 at t1; fill_valid=1 only at t5 with fill_addr=0x0000_1000 and fill_data=0xBBBB_0002_AAAA_0001; busy=0 at t6.
3. Backpressure: as case 2 but dram_req_ready=0 for cycles t1–t4, then 1 at t5 -> dram_req_valid=1 and dram_req_addr=0x1000 held constant t1–t5; exactly one handshake.
4. Flush before handshake: miss at t0, ready=0, flush=1 at t2 -> dram_req_valid=0 from t3, state IDLE; no fill. A later stray beat is ignored.
5. Flush during WAIT: handshake at t1, flush at t2, beats at t3 and t4 -> fill_valid stays 0. A new miss at t5 (0x2000) is accepted: dram_req_valid=1 with addr 0x2000 at t6.
6. Miss while busy and flush+miss collision:
   - miss_valid pulses during WAIT -> ignored; still exactly one request.
   - In IDLE, miss_valid=1 and flush=1 in the same cycle -> no request.
